// File: rtl/song_sequencer.sv
// Autoplay note sequencer: walks a song from an internal 8-song ROM and emits
// note codes with a note-on qualifier, per-note durations, articulation gaps and optional looping.
module song_sequencer #(
  parameter int unsigned UNIT_TICKS = 12_500_000,
  parameter int unsigned GAP_TICKS  = 1_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] song_select,
  input  logic       loop,
  input  logic       pause,
  output logic [3:0] note,
  output logic       note_on,
  output logic       busy,
  output logic       song_done,
  output logic [5:0] note_idx
);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

  localparam int TW = ($clog2(UNIT_TICKS) > 28) ? $clog2(UNIT_TICKS) : 28;
  localparam logic [TW-1:0] PLAY_LAST = TW'(UNIT_TICKS - GAP_TICKS - 1);
  localparam logic [TW-1:0] UNIT_LAST = TW'(UNIT_TICKS - 1);

  state_t        state, state_d;
  logic [2:0]    sel_q, sel_d;
  logic [5:0]    idx_d;
  logic [TW-1:0] tick, tick_d;
  logic [3:0]    units, units_d;
  logic [7:0]    rom_q;
  logic [3:0]    note_d;
  logic          note_on_d;

  // Song table: {note, dur}; dur = 0 marks end of song.
  function automatic logic [7:0] rom_lookup(input logic [2:0] sel, input logic [5:0] a);
    logic [7:0] d;
    d = 8'h00;
    case (sel)
      3'd0: case (a)
        6'd0: d = 8'h12;  6'd1: d = 8'h01;  6'd2: d = 8'h31;
        default: d = 8'h00;
      endcase
      3'd1: case (a)
        6'd0: d = 8'h51;  6'd1: d = 8'h62;
        default: d = 8'h00;
      endcase
      3'd2: case (a)
        6'd0: d = 8'h14;  6'd1: d = 8'h34;  6'd2: d = 8'h54;  6'd3: d = 8'h18;
        default: d = 8'h00;
      endcase
      3'd3: case (a)
        6'd0: d = 8'h11;  6'd1: d = 8'h21;  6'd2: d = 8'h31;  6'd3: d = 8'h41;
        6'd4: d = 8'h51;  6'd5: d = 8'h61;  6'd6: d = 8'h71;  6'd7: d = 8'h84;
        default: d = 8'h00;
      endcase
      3'd4: case (a)
        6'd0: d = 8'h32;  6'd1: d = 8'h32;  6'd2: d = 8'h02;  6'd3: d = 8'h52;
        6'd4: d = 8'h34;
        default: d = 8'h00;
      endcase
      3'd5: case (a)
        6'd0: d = 8'h88;  6'd1: d = 8'h01;  6'd2: d = 8'h98;
        default: d = 8'h00;
      endcase
      3'd6: case (a)
        6'd0: d = 8'hA1;  6'd1: d = 8'hB1;  6'd2: d = 8'hC1;  6'd3: d = 8'hD2;
        6'd4: d = 8'h02;  6'd5: d = 8'hD2;  6'd6: d = 8'hC1;  6'd7: d = 8'hB1;
        6'd8: d = 8'hA4;
        default: d = 8'h00;
      endcase
      default: d = 8'h00;
    endcase
    return d;
  endfunction

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state;
    sel_d     = sel_q;
    idx_d     = note_idx;
    tick_d    = tick;
    units_d   = units;
    note_d    = note;
    note_on_d = 1'b0;
    case (state)
      IDLE: begin
        note_d  = '0;
        idx_d   = '0;
        tick_d  = '0;
        units_d = '0;
        if (start) begin
          sel_d   = song_select;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (rom_q[3:0] != 4'd0) begin
          note_d    = rom_q[7:4];
          note_on_d = (rom_q[7:4] != 4'd0);
          tick_d    = '0;
          units_d   = rom_q[3:0];
          state_d   = PLAY;
        end else if (note_idx == 6'd0 || !loop) begin
          note_d  = '0;
          state_d = DONE;
        end else begin
          idx_d = '0;
        end
      end
      PLAY: begin
        if (!pause) begin
          if (units == 4'd1 && tick == PLAY_LAST) begin
            tick_d  = tick + 1'b1;
            state_d = GAP;
          end else begin
            note_on_d = (note != 4'd0);
            if (tick == UNIT_LAST) begin
              tick_d  = '0;
              units_d = units - 4'd1;
            end else begin
              tick_d = tick + 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (!pause) begin
          if (tick != UNIT_LAST) begin
            tick_d = tick + 1'b1;
          end else if (note_idx != 6'd63) begin
            idx_d   = note_idx + 6'd1;
            state_d = LOAD;
          end else if (loop) begin
            // Past the last ROM slot counts as an implicit end-of-song marker.
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            note_d  = '0;
            state_d = DONE;
          end
        end
      end
      DONE:    note_d = '0;
      default: state_d = IDLE;
    endcase
    // Abort wins over pause and end-of-song handling.
    if (state != IDLE && !start) begin
      state_d   = IDLE;
      note_d    = '0;
      note_on_d = 1'b0;
      idx_d     = '0;
      tick_d    = '0;
      units_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sel_q     <= '0;
      note_idx  <= '0;
      tick      <= '0;
      units     <= '0;
      rom_q     <= '0;
      note      <= '0;
      note_on   <= 1'b0;
      busy      <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state     <= state_d;
      sel_q     <= sel_d;
      note_idx  <= idx_d;
      tick      <= tick_d;
      units     <= units_d;
      rom_q     <= rom_lookup(sel_d, idx_d);
      note      <= note_d;
      note_on   <= note_on_d;
      busy      <= (state_d != IDLE);
      song_done <= (state_d == DONE) && (state != DONE);
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: stimulus queues expected note runs and
// song_done events; a negedge monitor measures note_on runs and compares.
module tb_song_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] song_select;
  logic       loop;
  logic       pause;
  logic [3:0] note;
  logic       note_on;
  logic       busy;
  logic       song_done;
  logic [5:0] note_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_done;
    logic [3:0] note;
    int         len;
    logic [5:0] idx;
    int         gap;   // low cycles before the run; -1 = don't care
  } exp_t;

  exp_t sb[$];

  song_sequencer #(.UNIT_TICKS(4), .GAP_TICKS(1)) dut (
    .clk(clk), .rst(rst), .start(start), .song_select(song_select),
    .loop(loop), .pause(pause), .note(note), .note_on(note_on),
    .busy(busy), .song_done(song_done), .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void push_note(input int n, input int len, input int idx, input int gap);
    exp_t e;
    e.is_done = 1'b0;
    e.note    = 4'(n);
    e.len     = len;
    e.idx     = 6'(idx);
    e.gap     = gap;
    sb.push_back(e);
  endfunction

  function automatic void push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.note    = '0;
    e.len     = 0;
    e.idx     = '0;
    e.gap     = -1;
    sb.push_back(e);
  endfunction

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    check(name, sb.size(), 0);
  endtask

  task automatic stop_song();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("stop_busy", busy, 0);
    check("stop_note", note, 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: measures each note_on run and each song_done pulse.
  always @(negedge clk) begin : monitor
    exp_t       e;
    bit         prev_on;
    bit         prev_done;
    int         run_len;
    int         run_gap;
    int         gap_cnt;
    logic [3:0] run_note;
    logic [5:0] run_idx;
    if (song_done) begin
      check("done_width", int'(prev_done), 0);
      if (sb.size() == 0) check("done_unexpected", sb.size(), 1);
      else begin
        e = sb.pop_front();
        check("done_order", int'(e.is_done), 1);
      end
    end
    prev_done = song_done;
    if (note_on) begin
      if (!prev_on) begin
        run_len  = 1;
        run_note = note;
        run_idx  = note_idx;
        run_gap  = gap_cnt;
      end else begin
        run_len++;
      end
      gap_cnt = 0;
    end else begin
      if (prev_on) begin
        if (sb.size() == 0) check("run_unexpected", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check("run_order", int'(e.is_done), 0);
          check("run_note", run_note, e.note);
          check("run_idx", run_idx, e.idx);
          check("run_len", run_len, e.len);
          if (e.gap >= 0) check("run_gap", run_gap, e.gap);
        end
      end
      gap_cnt++;
    end
    prev_on = note_on;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d pending, expected 0", sb.size());
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    rst = 1'b0; start = 1'b0; song_select = 3'd0; loop = 1'b0; pause = 1'b0;
    #12;
    check("rst_note", note, 0);
    check("rst_note_on", note_on, 0);
    check("rst_busy", busy, 0);
    check("rst_song_done", song_done, 0);
    check("rst_note_idx", note_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: song 0, no loop
    push_note(1, 7, 0, -1); push_note(3, 3, 2, 7); push_done();
    song_select = 3'd0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    check("t1_load_busy", busy, 1);
    check("t1_load_note_on", note_on, 0);
    @(posedge clk); @(negedge clk);
    check("t1_first_note", note, 1);
    check("t1_first_note_on", note_on, 1);
    check("t1_first_idx", note_idx, 0);
    wait_drain("t1_drain", 100);
    repeat (3) begin
      @(negedge clk);
      check("t1_done_busy", busy, 1);
      check("t1_done_pulse_low", song_done, 0);
      check("t1_done_note_on", note_on, 0);
    end
    stop_song();

    // 2: song 0, loop
    push_note(1, 7, 0, -1); push_note(3, 3, 2, 7); push_note(1, 7, 0, 3);
    loop = 1'b1; start = 1'b1;
    wait_drain("t2_drain", 200);
    stop_song();
    loop = 1'b0;

    // 3: empty song 7 with loop
    push_done();
    song_select = 3'd7; loop = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    check("t3_load_done", song_done, 0);
    check("t3_load_busy", busy, 1);
    @(posedge clk); @(negedge clk);
    check("t3_done_pulse", song_done, 1);
    @(posedge clk); @(negedge clk);
    check("t3_done_once", song_done, 0);
    check("t3_busy_held", busy, 1);
    check("t3_note_on", note_on, 0);
    wait_drain("t3_drain", 20);
    stop_song();
    loop = 1'b0;

    // 4: pause for 10 cycles in the middle of note 1
    push_note(1, 3, 0, -1); push_note(1, 4, 0, 10); push_note(3, 3, 2, 7); push_done();
    song_select = 3'd0; start = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("t4_note_on", note_on, 1);
    @(posedge clk); @(posedge clk); @(negedge clk);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      check("t4_pause_note_on", note_on, 0);
      check("t4_pause_note", note, 1);
      check("t4_pause_idx", note_idx, 0);
    end
    pause = 1'b0;
    wait_drain("t4_drain", 100);
    stop_song();

    // 5: abort during PLAY, then restart on song 1 (late select change ignored)
    push_note(1, 2, 0, -1);
    start = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("t5_note_on", note_on, 1);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    check("t5_abort_note", note, 0);
    check("t5_abort_note_on", note_on, 0);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_idx", note_idx, 0);
    push_note(5, 3, 0, -1); push_note(6, 7, 1, 2); push_done();
    song_select = 3'd1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    song_select = 3'd3;
    @(posedge clk); @(negedge clk);
    check("t5_new_note", note, 5);
    check("t5_new_idx", note_idx, 0);
    wait_drain("t5_drain", 100);
    stop_song();

    // 6: asynchronous reset during GAP, restart with start held
    push_note(1, 7, 0, -1);
    song_select = 3'd0; start = 1'b1;
    repeat (9) @(posedge clk);
    #2;
    check("t6_gap_note", note, 1);
    check("t6_gap_note_on", note_on, 0);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_note", note, 0);
    check("t6_rst_note_on", note_on, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", song_done, 0);
    check("t6_rst_idx", note_idx, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    push_note(1, 7, 0, -1); push_note(3, 3, 2, 7); push_done();
    @(posedge clk); @(negedge clk);
    check("t6_load_busy", busy, 1);
    check("t6_load_note_on", note_on, 0);
    @(posedge clk); @(negedge clk);
    check("t6_restart_note", note, 1);
    check("t6_restart_note_on", note_on, 1);
    check("t6_restart_idx", note_idx, 0);
    wait_drain("t6_drain", 100);
    stop_song();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
